// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared widths, FSM states and saturating-add constants for the SNN integrator
package snn_pkg;

  localparam int SUM_WIDTH_DEF  = 9;
  localparam int POT_WIDTH_DEF  = 16;
  // One guard bit is enough because SUM_WIDTH is always narrower than POT_WIDTH
  localparam int SAT_GUARD_BITS = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/neuron_update_unit.sv
// rtl/neuron_update_unit.sv - leak, threshold compare and reset for one neuron (time-shared)
// Leak term V - (V >>> shift) exists only when SNN_LEAK_EN is defined.
module neuron_update_unit
  import snn_pkg::*;
#(
  parameter int POT_WIDTH = POT_WIDTH_DEF
) (
  input  logic signed [POT_WIDTH-1:0] pot_i,
  input  logic signed [POT_WIDTH-1:0] threshold_i,
  input  logic signed [POT_WIDTH-1:0] reset_pot_i,
`ifdef SNN_LEAK_EN
  input  logic        [3:0]           leak_shift_i,
`endif
  output logic signed [POT_WIDTH-1:0] pot_o,
  output logic                        fire_o
);

  logic signed [POT_WIDTH-1:0] leaked;

`ifdef SNN_LEAK_EN
  // Same-sign shift never exceeds |V|, so the subtraction cannot overflow
  assign leaked = pot_i - (pot_i >>> leak_shift_i);
`else
  assign leaked = pot_i;
`endif

  assign fire_o = (leaked >= threshold_i);
  assign pot_o  = fire_o ? reset_pot_i : leaked;

endmodule

// File: rtl/snn_neuron_integrator.sv
// rtl/snn_neuron_integrator.sv - time-multiplexed LIF neuron integrator with per-tick spike sweep
// Optional leak enabled by defining SNN_LEAK_EN.
module snn_neuron_integrator
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int POT_WIDTH   = POT_WIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic signed [SUM_WIDTH-1:0]    sum_i,
  input  logic                           sum_valid_i,
  output logic                           sum_ready_o,
  input  logic [$clog2(NUM_NEURONS)-1:0] neuron_idx_i,
  input  logic                           tick_i,
  input  logic signed [POT_WIDTH-1:0]    threshold_i,
  input  logic signed [POT_WIDTH-1:0]    reset_pot_i,
  input  logic [3:0]                     leak_shift_i,
  output logic [NUM_NEURONS-1:0]         spike_o,
  output logic                           spike_valid_o,
  output logic                           busy_o
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int ACC_W = POT_WIDTH + SAT_GUARD_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

  state_t                      state;
  logic [IDX_W-1:0]            cnt;
  logic signed [POT_WIDTH-1:0] pot [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]      spike_build;
  logic [NUM_NEURONS-1:0]      spike_next;
  logic signed [POT_WIDTH-1:0] thr_q;
  logic signed [POT_WIDTH-1:0] rpot_q;
  logic signed [POT_WIDTH-1:0] upd_pot;
  logic                        upd_fire;
  logic [ACC_W-1:0]            acc;
  logic signed [POT_WIDTH-1:0] acc_sat;

  assign sum_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Guard-bit add: the two MSBs disagree exactly when the POT_WIDTH result overflowed
  assign acc = {pot[neuron_idx_i][POT_WIDTH-1], pot[neuron_idx_i]}
             + {{(ACC_W-SUM_WIDTH){sum_i[SUM_WIDTH-1]}}, sum_i};

  always_comb begin
    acc_sat = acc[POT_WIDTH-1:0];
    if (acc[ACC_W-1] != acc[ACC_W-2]) begin
      acc_sat = acc[ACC_W-1] ? POT_MIN : POT_MAX;
    end
  end

  always_comb begin
    spike_next      = spike_build;
    spike_next[cnt] = upd_fire;
  end

`ifdef SNN_LEAK_EN
  logic [3:0] lshift_q;
`else
  logic unused_leak_shift;
  assign unused_leak_shift = ^leak_shift_i;
`endif

  neuron_update_unit #(
    .POT_WIDTH (POT_WIDTH)
  ) u_update (
    .pot_i        (pot[cnt]),
    .threshold_i  (thr_q),
    .reset_pot_i  (rpot_q),
`ifdef SNN_LEAK_EN
    .leak_shift_i (lshift_q),
`endif
    .pot_o        (upd_pot),
    .fire_o       (upd_fire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      spike_build   <= '0;
      spike_o       <= '0;
      spike_valid_o <= 1'b0;
      thr_q         <= '0;
      rpot_q        <= '0;
`ifdef SNN_LEAK_EN
      lshift_q      <= '0;
`endif
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i] <= '0;
      end
    end else begin
      spike_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          // A sum arriving with the tick lands before neuron sweep reads it
          if (sum_valid_i) begin
            pot[neuron_idx_i] <= acc_sat;
          end
          if (tick_i) begin
            thr_q       <= threshold_i;
            rpot_q      <= reset_pot_i;
`ifdef SNN_LEAK_EN
            lshift_q    <= leak_shift_i;
`endif
            cnt         <= '0;
            spike_build <= '0;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          pot[cnt]    <= upd_pot;
          spike_build <= spike_next;
          cnt         <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            spike_o       <= spike_next;
            spike_valid_o <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/snn_neuron_integrator.md
SNN_NEURON_INTEGRATOR -- requirements
Module: snn_neuron_integrator

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 16, meaning the number of time-multiplexed neurons, which is a power of two and at least 2.
REQ-002 SHALL have parameter SUM_WIDTH, default 9, meaning the width of the signed adder-tree sum input.
REQ-003 SHALL have parameter POT_WIDTH, default 16, meaning the signed membrane-potential width, which is greater than SUM_WIDTH.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high; the design has one clock.
REQ-005 SHALL have ports: sum_i in SUM_WIDTH signed synaptic sum; sum_valid_i in 1; sum_ready_o out 1; neuron_idx_i in clog2(NUM_NEURONS) target neuron.
REQ-006 SHALL have ports: tick_i in 1 timestep end; threshold_i in POT_WIDTH signed; reset_pot_i in POT_WIDTH signed; leak_shift_i in 4 leak shift amount.
REQ-007 SHALL have ports: spike_o out NUM_NEURONS spike vector (bit i = neuron i); spike_valid_o out 1; busy_o out 1.

Function
REQ-008 SHALL implement FSM states IDLE, UPDATE, DONE, with the transitions IDLE->UPDATE on tick_i, UPDATE->DONE after neuron NUM_NEURONS-1, and DONE->IDLE unconditionally.
REQ-009 SHALL assert sum_ready_o only in IDLE; a sum is accepted when sum_valid_i&&sum_ready_o.
REQ-010 SHALL, on acceptance, set V[neuron_idx_i] <= sat(V[neuron_idx_i] + sext(sum_i)) at the next clock edge, saturating to the POT_WIDTH signed range.
REQ-011 SHALL, for back-to-back sums to the same index, accumulate both with no loss, using one sum per cycle at full throughput.
REQ-012 SHALL sample tick_i only in IDLE; tick_i in UPDATE/DONE is ignored.
REQ-013 SHALL, when a sum and tick_i arrive in the same IDLE cycle, accumulate the sum and then enter UPDATE, and the sum SHALL be included in that timestep.
REQ-014 SHALL latch threshold_i, reset_pot_i and leak_shift_i on tick acceptance, and use the latched values for the whole UPDATE.
REQ-015 SHALL, in UPDATE, process neuron i in UPDATE cycle i (i = 0..NUM_NEURONS-1), one neuron per cycle.
REQ-016 SHALL, per neuron, compute Vl = leak(V[i]), fire if Vl >= threshold (signed), and write V[i] <= fire ? reset_pot : Vl with spike bit i = fire.
REQ-017 SHALL assert spike_valid_o for exactly one cycle in DONE; a tick accepted at edge t gives spike_valid_o high in cycle t+NUM_NEURONS+1.
REQ-018 SHALL hold spike_o stable from DONE until the next DONE.
REQ-019 SHALL drive busy_o = (state != IDLE).

Reset
REQ-020 SHALL, on rst_i, immediately and asynchronously clear all V[i], spike_o and spike_valid_o to 0, set state to IDLE, set sum_ready_o = 1 after release, and clear the latched parameters to 0.
REQ-021 SHALL, on reset mid-UPDATE, discard the partially built spike vector; no spike_valid_o pulse is produced.

Configuration
REQ-022 SHALL, with SNN_LEAK_EN defined, compute leak(V) = V - (V >>> leak_shift), using an arithmetic shift; leak_shift = 0 means no leak.
REQ-023 SHALL, with SNN_LEAK_EN undefined, make leak(V) = V, leave leak_shift_i unused, and exclude the leak logic from synthesis.

Structure
REQ-024 SHALL take SUM_WIDTH and POT_WIDTH defaults, the FSM state enum, and the saturating-add width constants from shared package snn_pkg.
REQ-025 SHALL place the combinational leak/compare/reset logic in sub-module neuron_update_unit (one instance, time-shared).
REQ-026 SHALL store potentials in a register array of NUM_NEURONS x POT_WIDTH.

Verification
REQ-027 SHALL cover: sums +5, +3 to neuron 2, threshold 8, tick -> spike_o = 0x0004, V[2] = reset_pot (0), spike_valid_o at tick+17.
REQ-028 SHALL cover: sum -100 to neuron 0 repeated 400 times -> V[0] saturates at -32768 with no wrap.
REQ-029 SHALL cover: sum_valid_i with tick_i in the same cycle, sum +10 to neuron 1, threshold 10 -> spike bit 1 set.
REQ-030 SHALL cover: sum_valid_i held during UPDATE -> sum_ready_o = 0 for 17 cycles, and the sum is accepted after return to IDLE.
REQ-031 SHALL cover: SNN_LEAK_EN defined, V[3] = 64, leak_shift 2, threshold 100, tick -> V[3] = 48, no spike; with the macro undefined, V[3] = 64.
REQ-032 SHALL cover: rst_i asserted in UPDATE cycle 5 -> outputs 0 immediately, state IDLE, no spike_valid_o pulse.
